// File: rtl/demux_8x_deser.sv
// demux_8x_deser: 1-to-N deserializer that steers samples into slots of a
// parallel frame, with early termination (in_last) and zero fill.
module demux_8x_deser #(
  parameter int DATA_W = 12,
  parameter int N      = 8,
  parameter int CNT_W  = $clog2(N) + 1
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                in_valid,
  input  logic [DATA_W-1:0]   in_data,
  input  logic                in_last,
  output logic                in_ready,
  output logic                out_valid,
  output logic [N*DATA_W-1:0] out_data,
  output logic [CNT_W-1:0]    out_count,
  input  logic                out_ready
);

  localparam int IDX_W = $clog2(N);
  localparam logic [0:0] S_FILL = 1'b0;
  localparam logic [0:0] S_HOLD = 1'b1;
  localparam logic [N-1:0] ONE = N'(1);

  logic [0:0]       state;
  logic [IDX_W-1:0] idx;
  logic             in_xfer;
  logic             done;
  logic [N-1:0]     wr_sel;
  logic [N-1:0]     clr_sel;

  assign out_valid = (state == S_HOLD);
  assign in_ready  = !rst && ((state == S_FILL) || out_ready);
  assign in_xfer   = in_valid && in_ready;

  // idx is always 0 in HOLD, so a restart sample lands in slot 0
  always_comb begin
    wr_sel  = '0;
    clr_sel = '0;
    done    = 1'b0;
    if (in_xfer) begin
      wr_sel = ONE << idx;
      done   = in_last || (idx == IDX_W'(N - 1));
      if (done)
        clr_sel = ~((wr_sel << 1) - ONE);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= S_FILL;
      idx       <= '0;
      out_data  <= '0;
      out_count <= '0;
    end else begin
      for (int k = 0; k < N; k++) begin
        if (wr_sel[k])
          out_data[k*DATA_W +: DATA_W] <= in_data;
        else if (clr_sel[k])
          out_data[k*DATA_W +: DATA_W] <= '0;
      end
      if (in_xfer) begin
        if (done) begin
          state     <= S_HOLD;
          idx       <= '0;
          out_count <= CNT_W'(idx) + CNT_W'(1);
        end else begin
          state <= S_FILL;
          idx   <= idx + 1'b1;
        end
      end else if (out_valid && out_ready) begin
        state <= S_FILL;
      end
    end
  end

endmodule

// File: tb/tb_demux_8x_deser.sv
// tb_demux_8x_deser: scenario tasks plus a queue-based frame model
// for the 8-slot deserializer.
module tb_demux_8x_deser;

  localparam int DW = 12;
  localparam int N  = 8;
  localparam int CW = 4;

  typedef struct {
    logic [N*DW-1:0] d;
    int              c;
  } frame_t;

  logic          clk = 1'b0;
  logic          rst;
  logic          in_valid;
  logic [DW-1:0] in_data;
  logic          in_last;
  logic          in_ready;
  logic          out_valid;
  logic [N*DW-1:0] out_data;
  logic [CW-1:0] out_count;
  logic          out_ready;

  int checks = 0;
  int failures = 0;

  logic          ir_s, ov_s;
  logic [N*DW-1:0] od_s;
  logic [CW-1:0] oc_s;

  logic [DW-1:0] cur[$];
  frame_t        exp_q[$];
  frame_t        got_q[$];

  demux_8x_deser #(.DATA_W(DW), .N(N), .CNT_W(CW)) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_data(in_data), .in_last(in_last),
    .in_ready(in_ready),
    .out_valid(out_valid), .out_data(out_data), .out_count(out_count),
    .out_ready(out_ready)
  );

  always #5 clk = ~clk;

  // One clock: drive at negedge, sample 1 time unit before posedge.
  task automatic cycle(input logic iv, input logic [DW-1:0] id,
                       input logic il, input logic ordy);
    frame_t f;
    in_valid = iv; in_data = id; in_last = il; out_ready = ordy;
    #4;
    ir_s = in_ready; ov_s = out_valid; od_s = out_data; oc_s = out_count;
    if (rst) begin
      cur.delete();
    end else begin
      if (ov_s && ordy) begin
        f.d = od_s; f.c = int'(oc_s);
        got_q.push_back(f);
      end
      if (iv && ir_s) begin
        cur.push_back(id);
        if (il || cur.size() == N) begin
          f.d = '0;
          for (int i = 0; i < cur.size(); i++)
            f.d[i*DW +: DW] = cur[i];
          f.c = cur.size();
          exp_q.push_back(f);
          cur.delete();
        end
      end
    end
    @(negedge clk);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    cycle(1'b0, '0, 1'b0, 1'b0);
    rst = 1'b0;
    exp_q.delete(); got_q.delete(); cur.delete();
  endtask

  task automatic test_reset();
    rst = 1'b1;
    cycle(1'b0, '0, 1'b0, 1'b0);
    cycle(1'b1, 12'h5a5, 1'b0, 1'b1);
    checks++;
    if (ir_s !== 1'b0 || ov_s !== 1'b0 || od_s !== '0 || oc_s !== '0) begin
      failures++;
      $display("FAIL reset: ir=%b ov=%b od=%h oc=%0d required 0 0 0 0",
               ir_s, ov_s, od_s, oc_s);
    end
    rst = 1'b0;
    exp_q.delete(); got_q.delete(); cur.delete();
  endtask

  task automatic test_full_frame();
    for (int i = 1; i <= 8; i++) begin
      cycle(1'b1, DW'(i), 1'b0, 1'b1);
      checks++;
      if (ir_s !== 1'b1 || ov_s !== 1'b0) begin
        failures++;
        $display("FAIL full_fill[%0d]: ir=%b ov=%b required 1 0", i, ir_s, ov_s);
      end
    end
    cycle(1'b0, '0, 1'b0, 1'b1);
    checks++;
    if (ov_s !== 1'b1 || od_s !== 96'h008007006005004003002001 || oc_s !== 4'd8) begin
      failures++;
      $display("FAIL full_frame: ov=%b od=%h oc=%0d required 1 008007006005004003002001 8",
               ov_s, od_s, oc_s);
    end
    cycle(1'b0, '0, 1'b0, 1'b1);
    checks++;
    if (ov_s !== 1'b0) begin
      failures++;
      $display("FAIL full_one_cycle: ov=%b required 0", ov_s);
    end
  endtask

  task automatic test_short_frame();
    cycle(1'b1, 12'hAAA, 1'b0, 1'b1);
    cycle(1'b1, 12'hBBB, 1'b0, 1'b1);
    cycle(1'b1, 12'hCCC, 1'b1, 1'b1);
    cycle(1'b0, '0, 1'b0, 1'b1);
    checks++;
    if (ov_s !== 1'b1 || od_s !== 96'h000000000000000CCCBBBAAA || oc_s !== 4'd3) begin
      failures++;
      $display("FAIL short_frame: ov=%b od=%h oc=%0d required 1 000000000000000cccbbbaaa 3",
               ov_s, od_s, oc_s);
    end
  endtask

  task automatic test_backpressure();
    logic [N*DW-1:0] ref_d;
    ref_d = '0;
    for (int i = 0; i < 8; i++) begin
      cycle(1'b1, DW'(12'h200 + i), 1'b0, 1'b0);
      ref_d[i*DW +: DW] = DW'(12'h200 + i);
    end
    for (int k = 0; k < 5; k++) begin
      cycle(1'b1, 12'h111, 1'b0, 1'b0);
      checks++;
      if (ir_s !== 1'b0 || ov_s !== 1'b1 || od_s !== ref_d || oc_s !== 4'd8) begin
        failures++;
        $display("FAIL bp_stall[%0d]: ir=%b ov=%b od=%h oc=%0d required 0 1 %h 8",
                 k, ir_s, ov_s, od_s, oc_s, ref_d);
      end
    end
    cycle(1'b1, 12'h111, 1'b0, 1'b1);
    checks++;
    if (ir_s !== 1'b1) begin
      failures++;
      $display("FAIL bp_release: ir=%b required 1", ir_s);
    end
    cycle(1'b0, '0, 1'b0, 1'b0);
    checks++;
    if (ov_s !== 1'b0 || od_s[DW-1:0] !== 12'h111) begin
      failures++;
      $display("FAIL bp_slot0: ov=%b slot0=%h required 0 111", ov_s, od_s[DW-1:0]);
    end
  endtask

  task automatic test_back_to_back();
    int bubbles;
    do_reset();
    bubbles = 0;
    for (int i = 0; i < 32; i++) begin
      cycle(1'b1, DW'($urandom), 1'b0, 1'b1);
      if (ir_s !== 1'b1) bubbles++;
    end
    for (int i = 0; i < 3; i++) cycle(1'b0, '0, 1'b0, 1'b1);
    checks++;
    if (bubbles != 0 || got_q.size() != 4 || exp_q.size() != 4) begin
      failures++;
      $display("FAIL b2b_count: bubbles=%0d frames=%0d required 0 4",
               bubbles, got_q.size());
    end else begin
      for (int i = 0; i < 4; i++) begin
        checks++;
        if (got_q[i].d !== exp_q[i].d || got_q[i].c != exp_q[i].c) begin
          failures++;
          $display("FAIL b2b_frame[%0d]: got %h/%0d required %h/%0d", i,
                   got_q[i].d, got_q[i].c, exp_q[i].d, exp_q[i].c);
        end
      end
    end
  endtask

  task automatic test_reset_mid();
    do_reset();
    for (int i = 0; i < 5; i++) cycle(1'b1, DW'($urandom), 1'b0, 1'b1);
    rst = 1'b1;
    cycle(1'b1, 12'hfff, 1'b0, 1'b1);
    checks++;
    if (ir_s !== 1'b0 || ov_s !== 1'b0) begin
      failures++;
      $display("FAIL midrst_during: ir=%b ov=%b required 0 0", ir_s, ov_s);
    end
    rst = 1'b0;
    for (int i = 0; i < 8; i++) begin
      cycle(1'b1, DW'(12'h100 + i), 1'b0, 1'b1);
      checks++;
      if (ov_s !== 1'b0) begin
        failures++;
        $display("FAIL midrst_after[%0d]: ov=%b required 0", i, ov_s);
      end
    end
    cycle(1'b0, '0, 1'b0, 1'b1);
    checks++;
    if (ov_s !== 1'b1 || od_s !== 96'h107106105104103102101100 || oc_s !== 4'd8 ||
        got_q.size() != 1) begin
      failures++;
      $display("FAIL midrst_frame: ov=%b od=%h oc=%0d n=%0d required 1 107106105104103102101100 8 1",
               ov_s, od_s, oc_s, got_q.size());
    end
  endtask

  task automatic test_random();
    logic iv, il, ordy, pov, pordy;
    logic [DW-1:0] id;
    logic [N*DW-1:0] pod;
    logic [CW-1:0] poc;
    int bad;
    do_reset();
    iv = 0; il = 0; id = '0; pov = 0; pordy = 0; pod = '0; poc = '0;
    bad = 0;
    for (int t = 0; t < 3000; t++) begin
      if (!(iv && !ir_s)) begin
        iv = ($urandom % 4) != 0;
        id = DW'($urandom);
        il = ($urandom % 5) == 0;
      end
      ordy = ($urandom % 3) != 0;
      cycle(iv, id, il, ordy);
      if (pov && !pordy && (ov_s !== 1'b1 || od_s !== pod || oc_s !== poc)) bad++;
      pov = ov_s; pordy = ordy; pod = od_s; poc = oc_s;
    end
    for (int i = 0; i < 3; i++) cycle(1'b0, '0, 1'b0, 1'b1);
    checks++;
    if (bad != 0) begin
      failures++;
      $display("FAIL rnd_stable: violations=%0d required 0", bad);
    end
    checks++;
    if (got_q.size() != exp_q.size() || got_q.size() == 0) begin
      failures++;
      $display("FAIL rnd_count: got=%0d required %0d", got_q.size(), exp_q.size());
    end else begin
      int mism;
      mism = 0;
      for (int i = 0; i < got_q.size(); i++)
        if (got_q[i].d !== exp_q[i].d || got_q[i].c != exp_q[i].c) begin
          if (mism == 0)
            $display("FAIL rnd_frame[%0d]: got %h/%0d required %h/%0d", i,
                     got_q[i].d, got_q[i].c, exp_q[i].d, exp_q[i].c);
          mism++;
        end
      checks++;
      if (mism != 0) begin
        failures++;
        $display("FAIL rnd_frames: bad=%0d required 0", mism);
      end
    end
  endtask

  initial begin
    rst = 1'b1; in_valid = 1'b0; in_data = '0; in_last = 1'b0; out_ready = 1'b0;
    ir_s = 1'b0; ov_s = 1'b0; od_s = '0; oc_s = '0;
    @(negedge clk);
    test_reset();
    test_full_frame();
    test_short_frame();
    test_backpressure();
    test_back_to_back();
    test_reset_mid();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
